teknofest_prog_uart_rx: RTL

//  UART receiver with byte FIFO for the RAM programming path. Samples the serial

---
 rtl/teknofest_prog_uart_rx.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/teknofest_prog_uart_rx.sv
// UART 8N1 receiver feeding a first-word-fall-through byte FIFO for the RAM
// programming path; bytes are offered to the sequencer on a valid/ready port.
module teknofest_prog_uart_rx #(
  parameter int unsigned CPU_CLK    = 50_000_000,
  parameter int unsigned BAUD_RATE  = 9600,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          rx_i,
  output logic [7:0]                    data_o,
  output logic                          valid_o,
  input  logic                          ready_i,
  output logic [$clog2(FIFO_DEPTH):0]   level_o,
  output logic                          frame_err_o,
  output logic                          overflow_o,
  output logic                          busy_o
);

  localparam int unsigned DIV   = CPU_CLK / BAUD_RATE;
  localparam int unsigned CNT_W = $clog2(DIV);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t             r_state;
  logic [1:0]         r_sync;
  logic [CNT_W-1:0]   r_cnt;
  logic [2:0]         r_idx;
  logic [7:0]         r_shift;

  logic [7:0]         r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [LVL_W-1:0]   r_level;

  logic               w_rxs;
  logic               w_half;
  logic               w_full_bit;
  logic               w_push;
  logic               w_pop;
  logic               w_full;
  logic               w_wr;

  assign w_rxs      = r_sync[1];
  assign w_half     = (r_cnt == CNT_W'(DIV / 2 - 1));
  assign w_full_bit = (r_cnt == CNT_W'(DIV - 1));

  // Completed byte with a good stop bit, offered to the FIFO this cycle.
  assign w_push = (r_state == S_STOP) && w_full_bit && w_rxs;
  assign w_pop  = valid_o && ready_i;
  assign w_full = (r_level == LVL_W'(FIFO_DEPTH));
  assign w_wr   = w_push && (!w_full || w_pop);

  assign valid_o = (r_level != '0);
  assign level_o = r_level;
  assign data_o  = r_mem[r_rd_ptr];
  assign busy_o  = (r_state != S_IDLE);

  // Two-flop synchroniser, idles high so reset does not look like a start bit.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_sync <= 2'b11;
    end else begin
      r_sync <= {r_sync[0], rx_i};
    end
  end

  // Receiver FSM; every sample point lands mid-bit.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_shift     <= '0;
      frame_err_o <= 1'b0;
    end else begin
      frame_err_o <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (!w_rxs) begin
            r_state <= S_START;
          end
        end
        S_START: begin
          if (w_half) begin
            r_cnt <= '0;
            r_idx <= '0;
            r_state <= w_rxs ? S_IDLE : S_DATA;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_DATA: begin
          if (w_full_bit) begin
            r_cnt   <= '0;
            r_shift <= {w_rxs, r_shift[7:1]};
            if (r_idx == 3'd7) begin
              r_state <= S_STOP;
            end else begin
              r_idx <= r_idx + 3'd1;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_STOP: begin
          if (w_full_bit) begin
            r_cnt       <= '0;
            r_state     <= S_IDLE;
            frame_err_o <= !w_rxs;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  // Byte FIFO; a push into a full FIFO succeeds only when a pop frees the head slot.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      overflow_o <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      overflow_o <= w_push && w_full && !w_pop;
      if (w_wr) begin
        r_mem[r_wr_ptr] <= r_shift;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_wr, w_pop})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
    end
  end

endmodule
